condlogic: RTL and testbench

Conditional-execution stage of the single-cycle ARM datapath. It sits directly downstream of the instruction decoder. It takes the decoder's raw write-enables (PCS, RegW, MemW), the 2-bit flag-write group request and the instruction's condition field, and evaluates the condition against the architectural NZCV flags. It drives the qualified PCSrc, RegWrite and MemWrite to the datapath, and owns the NZCV flag register, which updates from the ALU's flags.

---
 rtl/condlogic_if.sv | 26 ++
 rtl/condlogic.sv | 61 ++++++
 tb/tb_condlogic.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/condlogic_if.sv
// Decoder/datapath-facing bundle of the conditional-execution stage.
// The slave side is condlogic; the master side is the decoder plus datapath.
interface condlogic_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, Stall,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, Stall,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/condlogic.sv
// Conditional-execution stage: evaluates Cond against the registered NZCV,
// qualifies the decoder's write enables and owns the two-group flag register.
module condlogic (
    input  logic        clk,
    input  logic        reset_n,
    condlogic_if.slave  bus
);
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;
    logic       go;
    logic [1:0] flag_write;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Uses only the registered flags, never ALUFlags, so an instruction's own
    // flag update cannot influence its own condition.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign go         = cond_ex & ~bus.Stall;
    assign flag_write = bus.FlagW & {2{go}};

    always_comb begin
        flags_d = flags_q;
        if (flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
        if (flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flags_q <= 4'b0000;
        else          flags_q <= flags_d;
    end

    // reset_n gates combinationally so no write escapes while reset is held.
    assign bus.PCSrc    = bus.PCS  & go & reset_n;
    assign bus.RegWrite = bus.RegW & go & reset_n;
    assign bus.MemWrite = bus.MemW & go & reset_n;
    assign bus.CondEx   = cond_ex;
    assign bus.Flags    = flags_q;
endmodule

// File: tb/tb_condlogic.sv
// Directed and randomized checks of condlogic against a behavioural model.
module tb_condlogic;
    logic clk;
    logic reset_n;
    condlogic_if bus ();

    condlogic dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] m_flags;

    // Conditions come in complementary pairs: the even code is the base
    // test and the odd code is its inverse (AL/never for 111x).
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic rw, input logic mw, input logic st);
        bus.Cond = c; bus.ALUFlags = alu; bus.FlagW = fw;
        bus.PCS = pcs; bus.RegW = rw; bus.MemW = mw; bus.Stall = st;
    endtask

    // Check the combinational outputs from the model, then clock and update it.
    task automatic check_outs(input string tag);
        logic cex, g;
        cex = ref_cond(bus.Cond, m_flags);
        g   = cex & ~bus.Stall & reset_n;
        chk({tag, "_condex"},   {3'b0, bus.CondEx},   {3'b0, cex});
        chk({tag, "_pcsrc"},    {3'b0, bus.PCSrc},    {3'b0, bus.PCS & g});
        chk({tag, "_regwrite"}, {3'b0, bus.RegWrite}, {3'b0, bus.RegW & g});
        chk({tag, "_memwrite"}, {3'b0, bus.MemWrite}, {3'b0, bus.MemW & g});
    endtask

    task automatic tick_model(input string tag);
        logic upd;
        upd = ref_cond(bus.Cond, m_flags) & ~bus.Stall;
        if (upd && bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
        if (upd && bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
        @(posedge clk);
        #1;
        chk({tag, "_flags"}, bus.Flags, m_flags);
    endtask

    initial begin
        m_flags = 4'b0000;
        reset_n = 1'b0;
        drive(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        chk("rst_flags", bus.Flags, 4'b0000);
        chk("rst_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
        chk("rst_pcsrc", {3'b0, bus.PCSrc}, 4'b0000);
        bus.Cond = 4'b1110;
        #1;
        chk("rst_al_condex", {3'b0, bus.CondEx}, 4'b0001);
        chk("rst_al_memwrite", {3'b0, bus.MemWrite}, 4'b0000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // EQ fails with Z=0, NE passes
        drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        chk("eq_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
        chk("eq_flags", bus.Flags, 4'b0000);
        drive(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        chk("ne_regwrite", {3'b0, bus.RegWrite}, 4'b0001);

        drive(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        tick_model("al_set");
        chk("al_set_lit", bus.Flags, 4'b0110);
        drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("eq_memwrite", {3'b0, bus.MemWrite}, 4'b0001);
        bus.Cond = 4'b1000; #1;
        chk("hi_condex", {3'b0, bus.CondEx}, 4'b0000);

        drive(4'b1110, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        tick_model("nz_only");
        chk("nz_only_lit", bus.Flags, 4'b1010);

        drive(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        tick_model("clear");
        drive(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("fail_pcsrc", {3'b0, bus.PCSrc}, 4'b0000);
        tick_model("fail_hold");
        chk("fail_hold_lit", bus.Flags, 4'b0000);

        drive(4'b1110, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1); #1;
        chk("stall_outs", {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'b0000);
        chk("stall_condex", {3'b0, bus.CondEx}, 4'b0001);
        tick_model("stall_hold");
        chk("stall_hold_lit", bus.Flags, 4'b0000);
        bus.Stall = 1'b0; #1;
        chk("unstall_outs", {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'b0111);
        tick_model("unstall");
        chk("unstall_lit", bus.Flags, 4'b0101);

        // Full condition sweep against every flag state
        for (int f = 0; f < 16; f++) begin
            drive(4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); #1;
            tick_model("sweep_load");
            for (int c = 0; c < 16; c++) begin
                drive(4'(c), 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0); #1;
                check_outs("sweep");
                if (c == 15) chk("nv_condex", {3'b0, bus.CondEx}, 4'b0000);
            end
        end

        // Asynchronous reset in the middle of a cycle with a pending update
        drive(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        tick_model("pre_rst");
        drive(4'b1110, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        m_flags = 4'b0000;
        #1;
        chk("mid_rst_flags", bus.Flags, 4'b0000);
        chk("mid_rst_outs", {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'b0000);
        bus.Cond = 4'b0001; #1;
        chk("mid_rst_ne", {3'b0, bus.CondEx}, 4'b0001);
        bus.Cond = 4'b1110;
        @(posedge clk); #1;
        chk("mid_rst_hold", bus.Flags, 4'b0000);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
            #1;
            check_outs("rand");
            tick_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
